wb_arb_wdt: RTL

//  Two-master Wishbone classic arbiter with a bus-cycle watchdog. It shares the SoC
//  bus between the SERV CPU (m0) and the SPI-slave bridge (m1) using round-robin.
//  The watchdog fabricates an ack plus a marker read word when a slave never acks,
//  so a missing or unmapped slave cannot hang either master.

---
 rtl/wb_arb_wdt_if.sv | 15 +
 rtl/wb_arb_wdt.sv | 101 ++++++++++
 2 files changed

// File: rtl/wb_arb_wdt_if.sv
// Wishbone classic signal bundle shared by the two masters and the arbitrated bus.
// The arbiter takes the slave view from each master and the master view toward the decoder.
interface wb_arb_wdt_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat;
  logic        ack;
  logic [31:0] rdt;

  modport master (output cyc, stb, we, sel, adr, dat, input ack, rdt);
  modport slave  (input cyc, stb, we, sel, adr, dat, output ack, rdt);
endinterface

// File: rtl/wb_arb_wdt.sv
// Round-robin Wishbone arbiter for two masters, with a watchdog that fabricates an ack
// and a marker read word when the addressed slave stalls for too long.
module wb_arb_wdt #(
  parameter int          WDT_BITS    = 7,
  parameter logic [31:0] TIMEOUT_RDT = 32'hdeaddead
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  wb_arb_wdt_if.slave         m0,
  wb_arb_wdt_if.slave         m1,
  wb_arb_wdt_if.master        bus,
  output logic                wdt_trip,
  output logic [7:0]          wdt_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [WDT_BITS-1:0] WCNT_ONE = {{(WDT_BITS-1){1'b0}}, 1'b1};

  state_t              state_reg;
  logic                last_gnt_reg;
  logic [WDT_BITS-1:0] wcnt_reg;
  logic [7:0]          wdt_count_reg;

  logic gnt0;
  logic gnt1;
  logic bus_stb;
  logic wdt_ack;

  always_comb begin
    gnt0    = (state_reg == GNT0);
    gnt1    = (state_reg == GNT1);
    bus_stb = (gnt0 & m0.stb) | (gnt1 & m1.stb);
    bus.cyc = (gnt0 & m0.cyc) | (gnt1 & m1.cyc);
    bus.stb = bus_stb;
    bus.we  = 1'b0;
    bus.sel = 4'h0;
    bus.adr = 32'h0;
    bus.dat = 32'h0;
    if (gnt0) begin
      bus.we  = m0.we;
      bus.sel = m0.sel;
      bus.adr = m0.adr;
      bus.dat = m0.dat;
    end else if (gnt1) begin
      bus.we  = m1.we;
      bus.sel = m1.sel;
      bus.adr = m1.adr;
      bus.dat = m1.dat;
    end
    // A real slave ack on the timeout cycle masks the forced one, so no double ack.
    wdt_ack  = bus_stb & ~bus.ack & (wcnt_reg == {WDT_BITS{1'b1}});
    wdt_trip = wdt_ack;
    m0.ack   = (bus.ack | wdt_ack) & gnt0;
    m1.ack   = (bus.ack | wdt_ack) & gnt1;
    m0.rdt   = wdt_ack ? TIMEOUT_RDT : bus.rdt;
    m1.rdt   = wdt_ack ? TIMEOUT_RDT : bus.rdt;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_reg     <= IDLE;
      last_gnt_reg  <= 1'b1;
      wcnt_reg      <= '0;
      wdt_count_reg <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          // On contention the master that was not granted last time wins.
          if (m0.cyc && (!m1.cyc || last_gnt_reg)) begin
            state_reg    <= GNT0;
            last_gnt_reg <= 1'b0;
          end else if (m1.cyc) begin
            state_reg    <= GNT1;
            last_gnt_reg <= 1'b1;
          end
        end
        GNT0:    if (!m0.cyc) state_reg <= IDLE;
        GNT1:    if (!m1.cyc) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (!bus_stb || bus.ack || wdt_ack) begin
        wcnt_reg <= '0;
      end else begin
        wcnt_reg <= wcnt_reg + WCNT_ONE;
      end

      if (wdt_ack && (wdt_count_reg != 8'hff)) begin
        wdt_count_reg <= wdt_count_reg + 8'd1;
      end
    end
  end

  assign wdt_count = wdt_count_reg;

endmodule
